// File: rtl/wavepredictor_v7_1_s00_axi_regs.sv
// AXI4-Lite register file for the wavepredictor RNN core: CTRL/SAMPLE/CFG/SCRATCH
// plus the enable level, clear pulse, config word and valid/ready sample stream.

module wavepredictor_v7_1_s00_axi_regs_lane (
  input  logic       en_i,
  input  logic [7:0] new_i,
  input  logic [7:0] old_i,
  output logic [7:0] byte_o
);
  assign byte_o = en_i ? new_i : old_i;
endmodule

module wavepredictor_v7_1_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            core_enable,
  output logic                            core_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_cfg,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   sample_tdata,
  output logic                            sample_tvalid,
  input  logic                            sample_tready
);
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int NB   = DW / 8;
  localparam int NREG = 4;

  localparam logic [1:0] IDX_CTRL   = 2'd0;
  localparam logic [1:0] IDX_SAMPLE = 2'd1;
  localparam logic [1:0] IDX_CFG    = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } addr_lat_t;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] data;
    logic [NB-1:0] strb;
  } w_lat_t;

  addr_lat_t                aw_q, aw_d, ar_q, ar_d;
  w_lat_t                   w_q, w_d;
  logic                     bvalid_q, bvalid_d;
  logic                     rvalid_q, rvalid_d;
  logic [DW-1:0]            rdata_q, rdata_d;
  logic [NREG-1:0][DW-1:0]  regs_q, regs_d;
  logic [DW-1:0]            tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     clear_q, clear_d;

  logic [DW-1:0] cur_w, merged_w;
  logic          stall, commit;

  // Ready is gated by reset so nothing handshakes while aresetn is low.
  assign s00_axi_awready = s00_axi_aresetn && !aw_q.vld && !bvalid_q;
  assign s00_axi_wready  = s00_axi_aresetn && !w_q.vld  && !bvalid_q;
  assign s00_axi_arready = s00_axi_aresetn && !rvalid_q && !ar_q.vld;

  // A SAMPLE write cannot overwrite a sample the core has not yet taken.
  assign stall  = (aw_q.idx == IDX_SAMPLE) && tvalid_q && !sample_tready;
  assign commit = aw_q.vld && w_q.vld && !stall;

  assign cur_w = regs_q[aw_q.idx];

  for (genvar b = 0; b < NB; b++) begin : g_lane
    wavepredictor_v7_1_s00_axi_regs_lane u_lane (
      .en_i   (w_q.strb[b]),
      .new_i  (w_q.data[8*b +: 8]),
      .old_i  (cur_w[8*b +: 8]),
      .byte_o (merged_w[8*b +: 8])
    );
  end

  always_comb begin
    aw_d     = aw_q;
    w_d      = w_q;
    ar_d     = ar_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    regs_d   = regs_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    clear_d  = 1'b0;

    if (s00_axi_awvalid && s00_axi_awready) begin
      aw_d.vld = 1'b1;
      aw_d.idx = s00_axi_awaddr[3:2];
    end
    if (s00_axi_wvalid && s00_axi_wready) begin
      w_d.vld  = 1'b1;
      w_d.data = s00_axi_wdata;
      w_d.strb = s00_axi_wstrb;
    end

    if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
    if (tvalid_q && sample_tready)  tvalid_d = 1'b0;

    if (commit) begin
      aw_d.vld          = 1'b0;
      w_d.vld           = 1'b0;
      bvalid_d          = 1'b1;
      regs_d[aw_q.idx]  = merged_w;
      clear_d           = (aw_q.idx == IDX_CTRL) && w_q.strb[0] && w_q.data[1];
      if (aw_q.idx == IDX_SAMPLE) begin
        tdata_d  = merged_w;
        tvalid_d = 1'b1;
      end
    end

    // Read pipeline: address captured, data registered one edge later from pre-commit state.
    if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
    if (ar_q.vld) begin
      rdata_d  = regs_q[ar_q.idx];
      rvalid_d = 1'b1;
      ar_d.vld = 1'b0;
    end
    if (s00_axi_arvalid && s00_axi_arready) begin
      ar_d.vld = 1'b1;
      ar_d.idx = s00_axi_araddr[3:2];
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_q     <= '0;
      w_q      <= '0;
      ar_q     <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      regs_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      aw_q     <= aw_d;
      w_q      <= w_d;
      ar_q     <= ar_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      regs_q   <= regs_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      clear_q  <= clear_d;
    end
  end

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign core_enable    = regs_q[IDX_CTRL][0];
  assign core_clear     = clear_q;
  assign core_cfg       = regs_q[IDX_CFG];
  assign sample_tdata   = tdata_q;
  assign sample_tvalid  = tvalid_q;

  logic unused_sig;
  assign unused_sig = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_wavepredictor_v7_1_s00_axi_regs.sv
// Directed bench for the wavepredictor AXI4-Lite register file.

module tb_wavepredictor_v7_1_s00_axi_regs;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        core_enable, core_clear;
  logic [31:0] core_cfg, sample_tdata;
  logic        sample_tvalid, sample_tready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wavepredictor_v7_1_s00_axi_regs dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .core_enable(core_enable), .core_clear(core_clear), .core_cfg(core_cfg),
    .sample_tdata(sample_tdata), .sample_tvalid(sample_tvalid),
    .sample_tready(sample_tready)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    bit aw_hs, w_hs;
    ok = 1'b0; resp = 2'bxx;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (!awvalid && !wvalid) break;
    end
    if (!awvalid && !wvalid) begin
      for (int c = 0; c < 40; c++) begin
        if (bvalid) begin
          resp = bresp; ok = 1'b1;
          step();
          break;
        end
        step();
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    bit hs;
    ok = 1'b0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      hs = arready;
      step();
      if (hs) begin arvalid = 1'b0; break; end
    end
    if (!arvalid) begin
      for (int c = 0; c < 40; c++) begin
        if (rvalid) begin
          d = rdata; resp = rresp; ok = 1'b1;
          step();
          break;
        end
        step();
      end
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step(); step();
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, sample_tvalid, core_clear, core_enable} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000",
                         {bvalid, rvalid, sample_tvalid, core_clear, core_enable});
    end
    checks++;
    if ({rdata, sample_tdata, core_cfg} !== 96'h0) begin
      errors++; $display("FAIL reset_data: rdata=%h tdata=%h cfg=%h want 0", rdata, sample_tdata, core_cfg);
    end
    aresetn = 1'b1;
    step();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL release_ready: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] d; bit ok;
    sample_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp, ok);
      checks++;
      if (!ok || resp !== 2'b00) begin
        errors++; $display("FAIL basic_wr%0d: ok=%0d bresp=%b want ok=1 bresp=00", i, ok, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp, ok);
      checks++;
      if (!ok || d !== 32'(i + 1) || resp !== 2'b00) begin
        errors++; $display("FAIL basic_rd%0d: ok=%0d rdata=%h rresp=%b want %h 00", i, ok, d, resp, i + 1);
      end
    end
    checks++;
    if (core_enable !== 1'b1 || core_cfg !== 32'd3) begin
      errors++; $display("FAIL basic_core: enable=%b cfg=%h want 1 3", core_enable, core_cfg);
    end
    checks++;
    if (sample_tvalid !== 1'b1 || sample_tdata !== 32'd2) begin
      errors++; $display("FAIL basic_sample: tvalid=%b tdata=%h want 1 2", sample_tvalid, sample_tdata);
    end
    sample_tready = 1'b1;
    step();
    sample_tready = 1'b0;
    checks++;
    if (sample_tvalid !== 1'b0) begin
      errors++; $display("FAIL basic_sample_drain: tvalid=%b want 0", sample_tvalid);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [31:0] d; bit ok;
    axi_write(4'hC, 32'hAABBCCDD, 4'hF, resp, ok);
    axi_write(4'hC, 32'h11223344, 4'b0101, resp, ok);
    axi_read(4'hC, d, resp, ok);
    checks++;
    if (!ok || d !== 32'hAA22CC44) begin
      errors++; $display("FAIL strobe_merge: ok=%0d rdata=%h want AA22CC44", ok, d);
    end
  endtask

  task automatic test_sample_stall();
    logic [1:0] resp; bit ok;
    sample_tready = 1'b0;
    axi_write(4'h4, 32'd5, 4'hF, resp, ok);
    checks++;
    if (!ok || sample_tvalid !== 1'b1 || sample_tdata !== 32'd5) begin
      errors++; $display("FAIL stall_first: ok=%0d tvalid=%b tdata=%h want 1 1 5", ok, sample_tvalid, sample_tdata);
    end
    awaddr = 4'h4; wdata = 32'd6; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0 || sample_tdata !== 32'd5) begin
      errors++; $display("FAIL stall_hold: bvalid=%b awready=%b wready=%b tdata=%h want 0 0 0 5",
                         bvalid, awready, wready, sample_tdata);
    end
    sample_tready = 1'b1;
    step();
    sample_tready = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || sample_tvalid !== 1'b1 || sample_tdata !== 32'd6) begin
      errors++; $display("FAIL stall_release: bvalid=%b tvalid=%b tdata=%h want 1 1 6",
                         bvalid, sample_tvalid, sample_tdata);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    sample_tready = 1'b1;
    step();
    sample_tready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || sample_tvalid !== 1'b0) begin
      errors++; $display("FAIL stall_drain: bvalid=%b tvalid=%b want 0 0", bvalid, sample_tvalid);
    end
  endtask

  task automatic test_aw_before_w();
    logic [1:0] resp; logic [31:0] d; bit ok;
    checks++;
    if (awready !== 1'b1) begin
      errors++; $display("FAIL awfirst_idle: awready=%b want 1", awready);
    end
    awaddr = 4'hC; awvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      errors++; $display("FAIL awfirst_latched: awready=%b wready=%b want 0 1", awready, wready);
    end
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL awfirst_nob: bvalid=%b want 0", bvalid);
    end
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL awfirst_latency: bvalid=%b one cycle after W want 0", bvalid);
    end
    step();
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL awfirst_bvalid: bvalid=%b bresp=%b want 1 00", bvalid, bresp);
    end
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL awfirst_bhold: bvalid=%b awready=%b wready=%b want 1 0 0", bvalid, awready, wready);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL awfirst_bdone: bvalid=%b awready=%b wready=%b want 0 1 1", bvalid, awready, wready);
    end
    axi_read(4'hC, d, resp, ok);
    checks++;
    if (!ok || d !== 32'h55) begin
      errors++; $display("FAIL awfirst_rd: ok=%0d rdata=%h want 55", ok, d);
    end
  endtask

  task automatic test_clear();
    logic [1:0] resp; logic [31:0] d; bit ok;
    int cnt = 0; int at = -1;
    awaddr = 4'h0; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (core_clear === 1'b1) begin cnt++; if (at < 0) at = c; end
    end
    bready = 1'b0;
    checks++;
    if (cnt != 1 || at != 1) begin
      errors++; $display("FAIL clear_pulse: high %0d cycles at %0d want 1 at 1", cnt, at);
    end
    axi_read(4'h0, d, resp, ok);
    checks++;
    if (!ok || d !== 32'h3 || core_enable !== 1'b1) begin
      errors++; $display("FAIL clear_rd: ok=%0d rdata=%h enable=%b want 3 1", ok, d, core_enable);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] d; bit ok;
    bit seen_resp = 1'b0;
    sample_tready = 1'b0;
    axi_write(4'h4, 32'd9, 4'hF, resp, ok);
    checks++;
    if (sample_tvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: tvalid=%b want 1", sample_tvalid);
    end
    awaddr = 4'h8; awvalid = 1'b1; araddr = 4'h8; arvalid = 1'b1; rready = 1'b0; bready = 1'b1;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    rready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bvalid === 1'b1 || rvalid === 1'b1) seen_resp = 1'b1;
    end
    bready = 1'b0; rready = 1'b0;
    checks++;
    if (seen_resp) begin
      errors++; $display("FAIL rstmid_noresp: stale response seen want none");
    end
    checks++;
    if (sample_tvalid !== 1'b0 || sample_tdata !== 32'd0 || core_enable !== 1'b0 || core_cfg !== 32'd0) begin
      errors++; $display("FAIL rstmid_outs: tvalid=%b tdata=%h en=%b cfg=%h want 0",
                         sample_tvalid, sample_tdata, core_enable, core_cfg);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp, ok);
      checks++;
      if (!ok || d !== 32'd0) begin
        errors++; $display("FAIL rstmid_rd%0d: ok=%0d rdata=%h want 0", i, ok, d);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    sample_tready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_strobe();
    test_sample_stall();
    test_aw_before_w();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
